// File: rtl/dac_spi_tx_if.sv
// Sample-in / SPI-out bundle between the waveform splitter and the DAC serialiser.
interface dac_spi_tx_if;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       dac_sclk;
    logic       dac_din;
    logic       dac_sync_n;
    logic       busy;
    logic [7:0] overrun_cnt;

    // Upstream side: supplies samples, observes the serial pins and status.
    modport master (
        output sample_in, sample_valid,
        input  dac_sclk, dac_din, dac_sync_n, busy, overrun_cnt
    );

    // Serialiser side.
    modport slave (
        input  sample_in, sample_valid,
        output dac_sclk, dac_din, dac_sync_n, busy, overrun_cnt
    );
endinterface

// File: rtl/dac_spi_tx.sv
// Serialises 8-bit samples into 16-bit SYNC_n-framed SPI frames for an AD5300-style DAC.
// A one-entry holding buffer decouples sample rate from frame rate; overwritten samples are counted.
module dac_spi_tx #(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned GAP_CYCLES = 2,
    parameter logic [1:0]  PD_MODE    = 2'b00
) (
    input  logic         clk,
    input  logic         rst,
    dac_spi_tx_if.slave  bus
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned TOG_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        hold_q, hold_d;
    logic              full_q, full_d;
    logic [14:0]       shreg_q, shreg_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [TOG_W-1:0]  tog_q, tog_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              sclk_q, sclk_d;
    logic              din_q, din_d;
    logic              sync_n_q, sync_n_d;
    logic [7:0]        ovr_q, ovr_d;
    logic              consume;
    logic [15:0]       frame;

    // Frame image of the buffered sample, bit 15 goes out first.
    assign frame = {2'b00, PD_MODE, hold_q, 4'b0000};

    // State and datapath registers; reset drops everything to idle levels at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            hold_q   <= 8'h00;
            full_q   <= 1'b0;
            shreg_q  <= 15'h0000;
            div_q    <= '0;
            tog_q    <= '0;
            gap_q    <= '0;
            sclk_q   <= 1'b1;
            din_q    <= 1'b0;
            sync_n_q <= 1'b1;
            ovr_q    <= 8'h00;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            full_q   <= full_d;
            shreg_q  <= shreg_d;
            div_q    <= div_d;
            tog_q    <= tog_d;
            gap_q    <= gap_d;
            sclk_q   <= sclk_d;
            din_q    <= din_d;
            sync_n_q <= sync_n_d;
            ovr_q    <= ovr_d;
        end
    end

    // Next-state: frame sequencing plus holding-buffer write/consume/overrun.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        full_d   = full_q;
        shreg_d  = shreg_q;
        div_d    = div_q;
        tog_d    = tog_q;
        gap_d    = gap_q;
        sclk_d   = sclk_q;
        din_d    = din_q;
        sync_n_d = sync_n_q;
        ovr_d    = ovr_q;
        consume  = 1'b0;

        case (state_q)
            IDLE: begin
                sclk_d   = 1'b1;
                din_d    = 1'b0;
                sync_n_d = 1'b1;
                if (full_q) begin
                    consume  = 1'b1;
                    shreg_d  = frame[14:0];
                    din_d    = frame[15];
                    sync_n_d = 1'b0;
                    div_d    = '0;
                    tog_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (div_q == DIV_W'(CLK_DIV - 1)) begin
                    // tog_q counts completed toggles, so this is toggle k = tog_q + 1
                    div_d = '0;
                    tog_d = tog_q + TOG_W'(1);
                    if (!tog_q[0]) begin
                        sclk_d = 1'b0;
                    end else if (tog_q == TOG_W'(31)) begin
                        sclk_d   = 1'b1;
                        sync_n_d = 1'b1;
                        din_d    = 1'b0;
                        gap_d    = '0;
                        state_d  = GAP;
                    end else begin
                        sclk_d  = 1'b1;
                        din_d   = shreg_q[14];
                        shreg_d = {shreg_q[13:0], 1'b0};
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A consumed entry can be refilled on the same edge without counting as an overrun.
        if (consume) begin
            full_d = 1'b0;
        end
        if (bus.sample_valid) begin
            hold_d = bus.sample_in;
            full_d = 1'b1;
            if (full_q && !consume && (ovr_q != 8'hFF)) begin
                ovr_d = ovr_q + 8'd1;
            end
        end
    end

    assign bus.dac_sclk    = sclk_q;
    assign bus.dac_din     = din_q;
    assign bus.dac_sync_n  = sync_n_q;
    assign bus.overrun_cnt = ovr_q;
    assign bus.busy        = (state_q != IDLE) || full_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: two instances (PD_MODE 00 and 11), a frame decoder per
// instance, a vector table of single-sample frames and hand-written multi-cycle sequences.
module tb_dac_spi_tx;

    logic clk = 1'b0;
    logic rst = 1'b0;

    dac_spi_tx_if if0 ();
    dac_spi_tx_if if1 ();

    dac_spi_tx #(.CLK_DIV(2), .GAP_CYCLES(2), .PD_MODE(2'b00)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    dac_spi_tx #(.CLK_DIV(2), .GAP_CYCLES(2), .PD_MODE(2'b11)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    always #5 clk = ~clk;

    logic [1:0] m_sclk, m_din, m_sync, m_busy;
    logic [7:0] m_ovr [2];
    assign m_sclk   = {if1.dac_sclk, if0.dac_sclk};
    assign m_din    = {if1.dac_din, if0.dac_din};
    assign m_sync   = {if1.dac_sync_n, if0.dac_sync_n};
    assign m_busy   = {if1.busy, if0.busy};
    assign m_ovr[0] = if0.overrun_cnt;
    assign m_ovr[1] = if1.overrun_cnt;

    // Frame decoder state and recorded frames per instance
    int          cyc = 0;
    int          nrec [2] = '{0, 0};
    int          viol [2] = '{0, 0};
    logic [15:0] fr_data  [2][512];
    int          fr_bits  [2][512];
    int          fr_low   [2][512];
    int          fr_start [2][512];
    logic [15:0] sh   [2];
    int          nb   [2];
    int          low  [2];
    int          st   [2];
    logic [1:0]  in_fr  = 2'b00;
    logic [1:0]  p_sclk = 2'b11;
    logic [1:0]  p_din  = 2'b00;
    logic [1:0]  p_sync = 2'b11;
    logic [7:0]  p_ovr [2] = '{8'h00, 8'h00};

    // Decode frames on SCLK falling edges and flag protocol violations, sampled mid-cycle.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                in_fr[i] <= 1'b0;
            end else begin
                if (p_sync[i] && !m_sync[i]) begin
                    in_fr[i] <= 1'b1;
                    sh[i]    <= 16'h0000;
                    nb[i]    <= 0;
                    low[i]   <= 1;
                    st[i]    <= cyc;
                end else if (in_fr[i] && !m_sync[i]) begin
                    low[i] <= low[i] + 1;
                    if (p_sclk[i] && !m_sclk[i]) begin
                        sh[i] <= {sh[i][14:0], m_din[i]};
                        nb[i] <= nb[i] + 1;
                    end
                end else if (in_fr[i] && m_sync[i]) begin
                    in_fr[i] <= 1'b0;
                    if (nrec[i] < 512) begin
                        fr_data[i][nrec[i]]  <= sh[i];
                        fr_bits[i][nrec[i]]  <= nb[i];
                        fr_low[i][nrec[i]]   <= low[i];
                        fr_start[i][nrec[i]] <= st[i];
                        nrec[i]              <= nrec[i] + 1;
                    end
                end
                if ((p_sclk[i] && !m_sclk[i] && (m_din[i] != p_din[i])) ||
                    ((m_sync[i] != p_sync[i]) && !m_sclk[i]) ||
                    (m_sync[i] && !m_sclk[i]) ||
                    (m_ovr[i] < p_ovr[i])) begin
                    viol[i] <= viol[i] + 1;
                end
            end
            p_sclk[i] <= m_sclk[i];
            p_din[i]  <= m_din[i];
            p_sync[i] <= m_sync[i];
            p_ovr[i]  <= m_ovr[i];
        end
    end

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int d, input logic v, input logic [7:0] s);
        if (d == 0) begin
            if0.sample_valid = v;
            if0.sample_in    = s;
        end else begin
            if1.sample_valid = v;
            if1.sample_in    = s;
        end
    endtask

    task automatic wait_rec(input int d, input int target, input int budget, input string nm);
        int n = 0;
        while (nrec[d] < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " frame_timeout"}, 32'(nrec[d] >= target), 32'd1);
    endtask

    task automatic wait_idle(input int d, input int budget, input string nm);
        int n = 0;
        while (m_busy[d] && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " idle_timeout"}, 32'(m_busy[d]), 32'd0);
    endtask

    // One strobe into an idle, empty instance; checks framing latency, content and return to idle.
    task automatic apply_vec(input int d, input logic [7:0] s, input logic [15:0] exp, input string nm);
        int base;
        base = nrec[d];
        @(negedge clk);
        drive(d, 1'b1, s);
        @(negedge clk);
        drive(d, 1'b0, 8'h00);
        chk({nm, " sync_before_load"}, 32'(m_sync[d]), 32'd1);
        chk({nm, " busy_after_strobe"}, 32'(m_busy[d]), 32'd1);
        @(negedge clk);
        chk({nm, " sync_low_next_edge"}, 32'(m_sync[d]), 32'd0);
        wait_rec(d, base + 1, 200, nm);
        chk({nm, " frame"}, 32'(fr_data[d][base]), 32'(exp));
        chk({nm, " bits"}, 32'(fr_bits[d][base]), 32'd16);
        chk({nm, " sync_low_cycles"}, 32'(fr_low[d][base]), 32'd64);
        repeat (3) @(negedge clk);
        chk({nm, " busy_end"}, 32'(m_busy[d]), 32'd0);
        chk({nm, " sclk_idle"}, 32'(m_sclk[d]), 32'd1);
        chk({nm, " din_idle"}, 32'(m_din[d]), 32'd0);
    endtask

    typedef struct {
        int          dut;
        logic [7:0]  sample;
        logic [15:0] frame;
    } vec_t;

    vec_t vt [6];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        int bad;
        int v;

        vt[0] = '{0, 8'hA5, 16'h0A50};
        vt[1] = '{0, 8'h00, 16'h0000};
        vt[2] = '{0, 8'h3C, 16'h03C0};
        vt[3] = '{0, 8'h81, 16'h0810};
        vt[4] = '{1, 8'hFF, 16'h3FF0};
        vt[5] = '{1, 8'h5A, 16'h35A0};

        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);

        // Reset state on both instances
        #1 rst = 1'b1;
        #2;
        for (int d = 0; d < 2; d++) begin
            chk("reset sclk", 32'(m_sclk[d]), 32'd1);
            chk("reset din", 32'(m_din[d]), 32'd0);
            chk("reset sync_n", 32'(m_sync[d]), 32'd1);
            chk("reset busy", 32'(m_busy[d]), 32'd0);
            chk("reset overrun", 32'(m_ovr[d]), 32'd0);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single-sample frames, both power-down modes
        for (int k = 0; k < 6; k++) begin
            apply_vec(vt[k].dut, vt[k].sample, vt[k].frame, $sformatf("vec%0d", k));
        end

        // Strobe on the exact load edge: old sample framed, new one follows, no overrun
        base = nrec[0];
        @(negedge clk);
        drive(0, 1'b1, 8'h11);
        @(negedge clk);
        drive(0, 1'b1, 8'h22);
        @(negedge clk);
        drive(0, 1'b0, 8'h00);
        wait_rec(0, base + 2, 400, "loadedge");
        chk("loadedge first", 32'(fr_data[0][base]), 32'h0110);
        chk("loadedge second", 32'(fr_data[0][base + 1]), 32'h0220);
        chk("loadedge spacing", 32'(fr_start[0][base + 1] - fr_start[0][base]), 32'd67);
        chk("loadedge overrun", 32'(m_ovr[0]), 32'd0);
        wait_idle(0, 200, "loadedge");

        // Strobes every 10 cycles: 01 sent, 02 and 03 overwritten, 04 sent
        base = nrec[0];
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            drive(0, 1'b1, 8'(j));
            @(negedge clk);
            drive(0, 1'b0, 8'h00);
            repeat (8) @(negedge clk);
        end
        wait_rec(0, base + 2, 300, "spaced");
        chk("spaced first", 32'(fr_data[0][base]), 32'h0010);
        chk("spaced second", 32'(fr_data[0][base + 1]), 32'h0040);
        chk("spaced overrun", 32'(m_ovr[0]), 32'd2);
        wait_idle(0, 200, "spaced");
        chk("spaced frame_count", 32'(nrec[0] - base), 32'd2);

        // Continuous strobing for 300 frames: overrun saturates, frames carry the latest sample
        base = nrec[0];
        v = 0;
        @(negedge clk);
        drive(0, 1'b1, 8'(v));
        n = 0;
        while (nrec[0] < base + 300 && n < 30000) begin
            @(negedge clk);
            v++;
            if0.sample_in = 8'(v);
            n++;
        end
        drive(0, 1'b0, 8'h00);
        chk("stream frame_timeout", 32'(nrec[0] >= base + 300), 32'd1);
        bad = 0;
        for (int j = base + 1; j < base + 300; j++) begin
            if ((8'(fr_data[0][j][11:4] - fr_data[0][j - 1][11:4]) != 8'd67) ||
                (fr_start[0][j] - fr_start[0][j - 1] != 67) ||
                (fr_low[0][j] != 64) || (fr_bits[0][j] != 16)) begin
                bad++;
            end
        end
        chk("stream bad_frames", 32'(bad), 32'd0);
        chk("stream overrun_sat", 32'(m_ovr[0]), 32'd255);
        wait_idle(0, 300, "stream");
        chk("stream overrun_hold", 32'(m_ovr[0]), 32'd255);

        // Reset mid-frame after toggle 9, then a clean frame
        base = nrec[0];
        @(negedge clk);
        drive(0, 1'b1, 8'h77);
        @(negedge clk);
        drive(0, 1'b0, 8'h00);
        n = 0;
        while (m_sync[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("midrst frame_started", 32'(m_sync[0]), 32'd0);
        repeat (18) @(negedge clk);
        chk("midrst sclk_low", 32'(m_sclk[0]), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("midrst sync_n", 32'(m_sync[0]), 32'd1);
        chk("midrst sclk", 32'(m_sclk[0]), 32'd1);
        chk("midrst din", 32'(m_din[0]), 32'd0);
        chk("midrst overrun", 32'(m_ovr[0]), 32'd0);
        chk("midrst busy", 32'(m_busy[0]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        apply_vec(0, 8'h3C, 16'h03C0, "after_rst");
        chk("after_rst frame_count", 32'(nrec[0] - base), 32'd1);

        chk("protocol dut0", 32'(viol[0]), 32'd0);
        chk("protocol dut1", 32'(viol[1]), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
